// File: rtl/cdc_event_arbiter.sv
// Round-robin server for synchronized event pulses from NUM_CH channels in the dest_clk domain.
// Keeps a saturating pending count per channel and offers one event per cycle on a valid/ready port.
module cdc_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 3,
  localparam int ID_W  = $clog2(NUM_CH)
) (
  input  logic              dest_clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] evt_pulse,
  input  logic              flush,
  output logic              out_valid,
  output logic [ID_W-1:0]   out_ch,
  input  logic              out_ready,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overflow,
  input  logic [NUM_CH-1:0] overflow_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t            state_r;
  logic [ID_W-1:0]   rr_ptr_r;
  logic [CNT_W-1:0]  cnt_r      [NUM_CH];
  logic [CNT_W-1:0]  cnt_next_s [NUM_CH];
  logic [NUM_CH-1:0] inc_s;
  logic [NUM_CH-1:0] dec_s;
  logic [NUM_CH-1:0] ovf_set_s;
  logic [NUM_CH-1:0] nz_s;
  logic              handshake_s;
  logic [ID_W-1:0]   next_ptr_s;
  logic [ID_W-1:0]   start_s;
  logic [ID_W-1:0]   pick_s;
  logic              found_s;

  // First set bit of req scanning start, start+1, ... wrapping at NUM_CH; MSB of result = found.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                            input logic [ID_W-1:0]   start);
    logic [ID_W:0] res;
    int            idx;
    res = {(ID_W+1){1'b0}};
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      idx = (idx >= NUM_CH) ? (idx - NUM_CH) : idx;
      res = req[idx] ? {1'b1, ID_W'(idx)} : res;
    end
    return res;
  endfunction

  // Next-count computation with saturation and overflow detection
  always_comb begin
    handshake_s = out_valid & out_ready;
    for (int i = 0; i < NUM_CH; i++) begin
      inc_s[i]      = evt_pulse[i];
      dec_s[i]      = handshake_s && (out_ch == ID_W'(i));
      cnt_next_s[i] = cnt_r[i];
      ovf_set_s[i]  = 1'b0;
      if (inc_s[i] && !dec_s[i]) begin
        if (cnt_r[i] == CNT_MAX) begin
          ovf_set_s[i] = 1'b1;
        end else begin
          cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
        end
      end else if (!inc_s[i] && dec_s[i]) begin
        cnt_next_s[i] = cnt_r[i] - CNT_W'(1);
      end else begin
        cnt_next_s[i] = cnt_r[i];
      end
      nz_s[i] = (cnt_next_s[i] != {CNT_W{1'b0}});
    end
  end

  // Arbitration start point and pick from the counts being written this edge
  always_comb begin
    next_ptr_s = (out_ch == ID_W'(NUM_CH - 1)) ? {ID_W{1'b0}} : (out_ch + ID_W'(1));
    if (state_r == OFFER) begin
      start_s = next_ptr_s;
    end else begin
      start_s = rr_ptr_r;
    end
    {found_s, pick_s} = rr_pick(nz_s, start_s);
  end

  // Pending counters and flags; overflow survives flush and only clears on request
  always_ff @(posedge dest_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
      pending  <= {NUM_CH{1'b0}};
      overflow <= {NUM_CH{1'b0}};
    end else if (flush) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
      pending  <= {NUM_CH{1'b0}};
      overflow <= overflow & ~overflow_clr;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= cnt_next_s[i];
      end
      pending  <= nz_s;
      overflow <= (overflow & ~overflow_clr) | ovf_set_s;
    end
  end

  // Offer FSM: an offer is held unchanged until the consumer takes it
  always_ff @(posedge dest_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      out_valid <= 1'b0;
      out_ch    <= {ID_W{1'b0}};
      rr_ptr_r  <= {ID_W{1'b0}};
    end else if (flush) begin
      state_r   <= IDLE;
      out_valid <= 1'b0;
      out_ch    <= {ID_W{1'b0}};
      rr_ptr_r  <= {ID_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            state_r   <= OFFER;
            out_valid <= 1'b1;
            out_ch    <= pick_s;
          end else begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
          end
        end
        OFFER: begin
          if (handshake_s) begin
            rr_ptr_r <= next_ptr_s;
            if (found_s) begin
              out_ch <= pick_s;
            end else begin
              state_r   <= IDLE;
              out_valid <= 1'b0;
            end
          end else begin
            state_r <= OFFER;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
